// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared register-address types for the pipeline control blocks
package pipeline_pkg;
  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/reg_match.sv
// reg_match: destination/source compare that never matches on x0
module reg_match import pipeline_pkg::*; #(
  parameter int W = REG_ADDR_W
) (
  input  logic [W-1:0] dst,
  input  logic [W-1:0] src,
  output logic         match
);
  assign match = (dst != W'(REG_ZERO)) && (dst == src);
endmodule

// File: rtl/hazard_detection.sv
// hazard_detection: load-use stall control with registered stall statistics
module hazard_detection #(
  parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_read,
  output logic                  o_pc_enable,
  output logic                  o_if_id_register_enable,
  output logic                  o_pipeline_stall,
  output logic                  o_stalled_q,
  output logic [CNT_W-1:0]      o_stall_count
);
  logic m1, m2, hazard, unused_id_rd;
  reg_match #(.W(REG_ADDR_W)) u_rs1 (.dst(i_ex_rd), .src(i_id_rs1), .match(m1));
  reg_match #(.W(REG_ADDR_W)) u_rs2 (.dst(i_ex_rd), .src(i_id_rs2), .match(m2));
  assign hazard                  = i_ex_read && (m1 || m2);
  assign o_pc_enable             = !hazard;
  assign o_if_id_register_enable = !hazard;
  assign o_pipeline_stall        = !hazard;
  assign unused_id_rd            = ^i_id_rd;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_stalled_q   <= 1'b0;
      o_stall_count <= '0;
    end else begin
      o_stalled_q <= hazard;
      if (hazard && o_stall_count != '1) o_stall_count <= o_stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_detection.sv
// tb_hazard_detection: directed and random checks against a rule-level model
module tb_hazard_detection;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1, rs2, id_rd, ex_rd;
  logic ex_read;
  logic pc_en, ifid_en, stall, stq, pc_en_s, ifid_en_s, stall_s, stq_s;
  logic [15:0] count;
  logic [2:0] count_s;
  int n_cmp = 0;
  int n_bad = 0;
  int cnt_m = 0;
  bit stq_m = 1'b0;
  always #5 clk = ~clk;
  hazard_detection dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rd(id_rd),
    .i_ex_rd(ex_rd), .i_ex_read(ex_read), .o_pc_enable(pc_en),
    .o_if_id_register_enable(ifid_en), .o_pipeline_stall(stall),
    .o_stalled_q(stq), .o_stall_count(count)
  );
  hazard_detection #(.CNT_W(3)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rd(id_rd),
    .i_ex_rd(ex_rd), .i_ex_read(ex_read), .o_pc_enable(pc_en_s),
    .o_if_id_register_enable(ifid_en_s), .o_pipeline_stall(stall_s),
    .o_stalled_q(stq_s), .o_stall_count(count_s)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cycle(input bit rn, input int a, input int b, input int d, input bit r);
    bit haz;
    @(negedge clk);
    rst_n = rn; rs1 = 5'(a); rs2 = 5'(b); ex_rd = 5'(d); ex_read = r; id_rd = 5'($urandom);
    #1;
    haz = r && d != 0 && (d == a || d == b);
    chk("pc_enable", {31'd0, pc_en}, {31'd0, !haz});
    chk("if_id_enable", {31'd0, ifid_en}, {31'd0, !haz});
    chk("pipeline_stall", {31'd0, stall}, {31'd0, !haz});
    chk("pc_enable_small", {31'd0, pc_en_s}, {31'd0, !haz});
    @(posedge clk);
    if (!rn) begin
      cnt_m = 0;
      stq_m = 1'b0;
    end else begin
      stq_m = haz;
      if (haz && cnt_m < 65535) cnt_m++;
    end
    #1;
    chk("stalled_q", {31'd0, stq}, {31'd0, stq_m});
    chk("stall_count", {16'd0, count}, cnt_m);
    chk("stalled_q_small", {31'd0, stq_s}, {31'd0, stq_m});
    chk("stall_count_sat", {29'd0, count_s}, cnt_m < 7 ? cnt_m : 7);
  endtask
  initial begin
    rst_n = 1'b0; rs1 = '0; rs2 = '0; id_rd = '0; ex_rd = '0; ex_read = 1'b0;
    cycle(0, 1, 2, 3, 1);
    cycle(1, 1, 2, 3, 1);
    cycle(1, 3, 2, 3, 1);
    cycle(1, 1, 3, 3, 1);
    cycle(1, 3, 3, 3, 0);
    cycle(1, 3, 3, 3, 1);
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 5, 0, 1);
    cycle(0, 3, 3, 3, 1);
    for (int i = 0; i < 3; i++) cycle(1, 7, 9, 7, 1);
    cycle(1, 7, 9, 8, 1);
    for (int i = 0; i < 10; i++) cycle(1, 4, 31, 31, 1);
    cycle(0, 4, 31, 31, 1);
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 39) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
